exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Parametrised exception controller that sits beside the main decoder and turns its per-instruction exception flags plus N external interrupt lines into a sequenced exception take/return protocol. It holds latched per-channel interrupt pending state, a mask register, and the exception status (ESR) and exception link (ELR) registers. It produces single-cycle redirect pulses for the fetch stage: vector on take, ELR on return.

## Interface
Parameters:
- N_IRQ, 4, number of external interrupt channels (1..13)
- PC_W, 64, PC / ELR width
- VECTOR, 64'h0000_0000_0000_00D8, exception vector address (truncated to PC_W)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- irq_i  in  N_IRQ  external interrupt lines, level, synchronous to clk
- mask_we  in  1  write strobe for mask register
- mask_wdata  in  N_IRQ  new mask; 1 = channel masked
- instr_valid  in  1  decode stage holds a real instruction this cycle
- not_an_instr  in  1  decoder flag: invalid opcode, qualified by instr_valid
- eret  in  1  decoder flag: ERET, qualified by instr_valid
- pc_i  in  PC_W  PC of the instruction in decode
- exc_o  out  1  one-cycle pulse: flush, redirect PC to exc_vector_o
- exc_vector_o  out  PC_W  constant VECTOR
- eret_o  out  1  one-cycle pulse: redirect PC to elr_o
- elr_o  out  PC_W  PC latched at take
- esr_o  out  4  EStatus latched at take
- pending_o  out  N_IRQ  pending register
- mask_o  out  N_IRQ  mask register
- in_handler_o  out  1  high in TAKE and HANDLER
- dbl_fault_o  out  1  sticky double fault (see Configuration)

## Operation
- Edge detect: irq_q <= irq_i; edge = irq_i & ~irq_q; pending <= (pending & ~clr) | edge. If edge and clr hit the same bit in one cycle, set wins.
- Eligible IRQ: pending & ~mask. The lowest-index eligible channel has priority.
- Mask write takes effect the cycle after mask_we.
- ESR encoding: invalid opcode = 4'b0010. Channel 0 = 4'b0001. Channel k≥1 = k+2.
- FSM states RUN, TAKE, HANDLER, RETURN (plus HALT under the macro):
  - RUN: if any eligible IRQ, go to TAKE. Latch ESR of the winning channel, ELR = pc_i, clear that pending bit.
  - RUN, otherwise: if instr_valid & not_an_instr, go to TAKE with ESR = 0010 and ELR = pc_i.
  - RUN, otherwise: if instr_valid & eret (ERET outside a handler), treat as invalid opcode: go to TAKE with ESR = 0010.
  - IRQ beats a simultaneous not_an_instr. The faulting instruction is flushed and re-faults after return.
  - TAKE: exc_o = 1, unconditionally go to HANDLER.
  - HANDLER: new exceptions are not taken; pending bits keep accumulating. On instr_valid & eret, go to RETURN.
  - RETURN: eret_o = 1, go to RUN. Pending IRQs are evaluated in RUN on the next cycle.
- ESR and ELR change only on entry to TAKE.

## Timing
- Reset values: state RUN, pending 0, irq_q 0, mask 0, esr_o 0, elr_o 0, exc_o 0, eret_o 0, in_handler_o 0, dbl_fault_o 0.
- Reset mid-handler returns to RUN immediately and discards pending state.
- Invalid opcode seen in RUN at edge N: exc_o high during cycle N+1 only. esr_o/elr_o valid from N+1.
- irq_i rises before edge N: pending bit set after N. Take at edge N+1; exc_o high during N+2.
- A held-high irq_i generates one pending event only. It must drop and rise again to re-pend.
- ERET seen in HANDLER at edge N: eret_o high during N+1. Earliest next exc_o is during N+3.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- EXC_CTRL_DBLFAULT_EN defined:
  - instr_valid & not_an_instr in HANDLER goes to HALT and sets dbl_fault_o.
  - HALT ignores all inputs and pulses nothing until reset.
  - ESR/ELR are frozen in HALT.
- Undefined: not_an_instr in HANDLER is ignored, and dbl_fault_o is tied to 0.

## Test plan
- Reset, then not_an_instr with pc_i=0x40 -> exc_o single pulse 1 cycle later; esr_o=0010, elr_o=0x40. Then eret -> eret_o pulse, back to RUN.
- N_IRQ=4, irq_i=4'b1010 rising together -> channel 1 taken first (esr_o=0011), pending_o=1000 after take. After ERET, channel 3 taken (esr_o=0101).
- mask=4'b0001 with irq_i[0] rising -> no exc_o, pending_o=0001. Mask write to 0 -> exc_o two cycles after mask_we, esr_o=0001.
- irq_i[2] edge and not_an_instr in the same RUN cycle -> esr_o=0100. After ERET, the re-presented invalid opcode is taken with esr_o=0010.
- With EXC_CTRL_DBLFAULT_EN: not_an_instr in HANDLER -> dbl_fault_o=1, no further exc_o/eret_o until reset. Without the macro: no effect, and a following ERET returns normally.
- Assert reset while in HANDLER with pending_o≠0 -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/exc_ctrl_if.sv
// ----------------------------------------------------------------------------
// exc_ctrl_if : decoder/fetch-side signal bundle for the exception controller.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface exc_ctrl_if #(
    parameter int N_IRQ = 4,
    parameter int PC_W  = 64
);
    logic [N_IRQ-1:0] irq_i;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic             instr_valid;
    logic             not_an_instr;
    logic             eret;
    logic [PC_W-1:0]  pc_i;
    logic             exc_o;
    logic [PC_W-1:0]  exc_vector_o;
    logic             eret_o;
    logic [PC_W-1:0]  elr_o;
    logic [3:0]       esr_o;
    logic [N_IRQ-1:0] pending_o;
    logic [N_IRQ-1:0] mask_o;
    logic             in_handler_o;
    logic             dbl_fault_o;

    modport master (
        output irq_i, mask_we, mask_wdata, instr_valid, not_an_instr, eret, pc_i,
        input  exc_o, exc_vector_o, eret_o, elr_o, esr_o, pending_o, mask_o,
               in_handler_o, dbl_fault_o
    );

    modport slave (
        input  irq_i, mask_we, mask_wdata, instr_valid, not_an_instr, eret, pc_i,
        output exc_o, exc_vector_o, eret_o, elr_o, esr_o, pending_o, mask_o,
               in_handler_o, dbl_fault_o
    );
endinterface

`default_nettype wire

// File: rtl/exc_ctrl.sv
// ----------------------------------------------------------------------------
// exc_ctrl : exception take/return sequencer with latched, maskable IRQs.
//            Optional double-fault halt enabled by EXC_CTRL_DBLFAULT_EN.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module exc_ctrl #(
    parameter int          N_IRQ  = 4,
    parameter int          PC_W   = 64,
    parameter logic [63:0] VECTOR = 64'h0000_0000_0000_00D8
) (
    input  wire logic  clk,
    input  wire logic  reset,
    exc_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        RUN     = 3'd0,
        TAKE    = 3'd1,
        HANDLER = 3'd2,
        RETURN  = 3'd3,
        HALT    = 3'd4
    } state_t;

    localparam logic [3:0] ESR_INVALID = 4'b0010;

    state_t           state;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] mask;
    logic [3:0]       esr;
    logic [PC_W-1:0]  elr;
    logic             exc_pulse;
    logic             eret_pulse;
    logic             in_handler;

    logic [N_IRQ-1:0] irq_rise;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] winner;
    logic [N_IRQ-1:0] clr;
    logic [3:0]       win_esr;
    logic             any_irq;

    assign irq_rise = bus.irq_i & ~irq_q;
    assign eligible = pending & ~mask;
    // Two's-complement trick isolates the lowest set bit: the priority winner.
    assign winner   = eligible & (~eligible + 1'b1);
    assign any_irq  = |eligible;
    assign clr      = (state == RUN) ? winner : '0;

    always_comb begin
        win_esr = 4'd0;
        for (int k = 0; k < N_IRQ; k++) begin
            if (winner[k]) begin
                win_esr = (k == 0) ? 4'd1 : 4'(k + 2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q   <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            irq_q   <= bus.irq_i;
            pending <= (pending & ~clr) | irq_rise;
            if (bus.mask_we) begin
                mask <= bus.mask_wdata;
            end
        end
    end

`ifdef EXC_CTRL_DBLFAULT_EN
    logic dbl_fault;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            esr        <= 4'd0;
            elr        <= '0;
            exc_pulse  <= 1'b0;
            eret_pulse <= 1'b0;
            in_handler <= 1'b0;
`ifdef EXC_CTRL_DBLFAULT_EN
            dbl_fault  <= 1'b0;
`endif
        end else begin
            exc_pulse  <= 1'b0;
            eret_pulse <= 1'b0;
            case (state)
                RUN: begin
                    if (any_irq) begin
                        state      <= TAKE;
                        esr        <= win_esr;
                        elr        <= bus.pc_i;
                        exc_pulse  <= 1'b1;
                        in_handler <= 1'b1;
                    end else if (bus.instr_valid && (bus.not_an_instr || bus.eret)) begin
                        // ERET outside a handler is reported as an invalid opcode.
                        state      <= TAKE;
                        esr        <= ESR_INVALID;
                        elr        <= bus.pc_i;
                        exc_pulse  <= 1'b1;
                        in_handler <= 1'b1;
                    end
                end
                TAKE: begin
                    state <= HANDLER;
                end
                HANDLER: begin
`ifdef EXC_CTRL_DBLFAULT_EN
                    if (bus.instr_valid && bus.not_an_instr) begin
                        state      <= HALT;
                        dbl_fault  <= 1'b1;
                        in_handler <= 1'b0;
                    end else
`endif
                    if (bus.instr_valid && bus.eret) begin
                        state      <= RETURN;
                        eret_pulse <= 1'b1;
                        in_handler <= 1'b0;
                    end
                end
                RETURN: begin
                    state <= RUN;
                end
`ifdef EXC_CTRL_DBLFAULT_EN
                HALT: begin
                    state <= HALT;
                end
`endif
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign bus.exc_o        = exc_pulse;
    assign bus.exc_vector_o = VECTOR[PC_W-1:0];
    assign bus.eret_o       = eret_pulse;
    assign bus.elr_o        = elr;
    assign bus.esr_o        = esr;
    assign bus.pending_o    = pending;
    assign bus.mask_o       = mask;
    assign bus.in_handler_o = in_handler;
`ifdef EXC_CTRL_DBLFAULT_EN
    assign bus.dbl_fault_o  = dbl_fault;
`else
    assign bus.dbl_fault_o  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_exc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_exc_ctrl : directed test-plan scenarios followed by random traffic,
//               all checked cycle by cycle against a behavioural model.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_exc_ctrl;
    localparam int          N    = 4;
    localparam int          PW   = 64;
    localparam logic [63:0] VEC  = 64'h0000_0000_0000_00D8;
`ifdef EXC_CTRL_DBLFAULT_EN
    localparam bit DBL_EN = 1'b1;
`else
    localparam bit DBL_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    exc_ctrl_if #(.N_IRQ(N), .PC_W(PW)) bus ();

    exc_ctrl #(.N_IRQ(N), .PC_W(PW), .VECTOR(VEC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: "busy" = inside an exception (take or handler),
    // pulses are one-shot flags that decay after a single cycle.
    logic [N-1:0]  m_pending, m_mask, m_prev_irq;
    logic [3:0]    m_esr;
    logic [PW-1:0] m_elr;
    bit            m_busy, m_exc, m_eret, m_halt, m_dbl;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] rise, elig, clr;
        bit           in_run, in_hdl, n_exc, n_eret;
        int           win;
        rise = bus.irq_i & ~m_prev_irq;
        if (reset) begin
            m_pending = '0; m_mask = '0; m_prev_irq = '0; m_esr = '0; m_elr = '0;
            m_busy = 0; m_exc = 0; m_eret = 0; m_halt = 0; m_dbl = 0;
            return;
        end
        in_run = !m_busy && !m_eret && !m_halt;
        in_hdl = m_busy && !m_exc;
        n_exc  = 0;
        n_eret = 0;
        clr    = '0;
        elig   = m_pending & ~m_mask;
        if (in_run) begin
            if (elig != 0) begin
                win = -1;
                for (int k = N - 1; k >= 0; k--) if (elig[k]) win = k;
                clr[win] = 1'b1;
                m_esr    = (win == 0) ? 4'd1 : 4'(win + 2);
                m_elr    = bus.pc_i;
                n_exc    = 1;
                m_busy   = 1;
            end else if (bus.instr_valid && (bus.not_an_instr || bus.eret)) begin
                m_esr  = 4'd2;
                m_elr  = bus.pc_i;
                n_exc  = 1;
                m_busy = 1;
            end
        end else if (in_hdl) begin
            if (DBL_EN && bus.instr_valid && bus.not_an_instr) begin
                m_halt = 1; m_dbl = 1; m_busy = 0;
            end else if (bus.instr_valid && bus.eret) begin
                m_busy = 0; n_eret = 1;
            end
        end
        m_exc      = n_exc;
        m_eret     = n_eret;
        m_pending  = (m_pending & ~clr) | rise;
        if (bus.mask_we) m_mask = bus.mask_wdata;
        m_prev_irq = bus.irq_i;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("exc_o",        64'(bus.exc_o),        64'(m_exc));
        check("eret_o",       64'(bus.eret_o),       64'(m_eret));
        check("esr_o",        64'(bus.esr_o),        64'(m_esr));
        check("elr_o",        64'(bus.elr_o),        64'(m_elr));
        check("pending_o",    64'(bus.pending_o),    64'(m_pending));
        check("mask_o",       64'(bus.mask_o),       64'(m_mask));
        check("in_handler_o", 64'(bus.in_handler_o), 64'(m_busy));
        check("dbl_fault_o",  64'(bus.dbl_fault_o),  64'(m_dbl));
        check("exc_vector_o", 64'(bus.exc_vector_o), VEC);
    endtask

    task automatic clear_flags();
        bus.instr_valid = 0; bus.not_an_instr = 0; bus.eret = 0; bus.mask_we = 0;
    endtask

    task automatic do_eret();
        bus.instr_valid = 1; bus.eret = 1;
        cyc();
        clear_flags();
        check("eret_pulse", 64'(bus.eret_o), 64'd1);
        cyc();
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        bus.irq_i = '0; bus.mask_wdata = '0; bus.pc_i = '0;
        clear_flags();
        reset = 1;
        cyc(); cyc();
        reset = 0;
        check("rst_state_in_handler", 64'(bus.in_handler_o), 64'd0);

        // Invalid opcode at 0x40, then return
        bus.instr_valid = 1; bus.not_an_instr = 1; bus.pc_i = 64'h40;
        cyc();
        clear_flags();
        check("inv_exc", 64'(bus.exc_o), 64'd1);
        check("inv_esr", 64'(bus.esr_o), 64'h2);
        check("inv_elr", bus.elr_o, 64'h40);
        cyc();
        check("inv_exc_single", 64'(bus.exc_o), 64'd0);
        do_eret();
        check("ret_in_run", 64'(bus.in_handler_o), 64'd0);

        // Two channels rising together: channel 1 before channel 3
        bus.irq_i = 4'b1010;
        cyc();
        check("two_pend", 64'(bus.pending_o), 64'b1010);
        cyc();
        check("ch1_esr", 64'(bus.esr_o), 64'h3);
        check("ch1_pend_left", 64'(bus.pending_o), 64'b1000);
        cyc();
        do_eret();
        cyc();
        check("ch3_exc", 64'(bus.exc_o), 64'd1);
        check("ch3_esr", 64'(bus.esr_o), 64'h5);
        cyc();
        do_eret();

        // Masked channel 0, then unmask
        bus.irq_i = '0; bus.mask_we = 1; bus.mask_wdata = 4'b0001;
        cyc();
        clear_flags();
        bus.irq_i = 4'b0001;
        cyc(); cyc(); cyc();
        check("masked_no_exc", 64'(bus.exc_o), 64'd0);
        check("masked_pend", 64'(bus.pending_o), 64'b0001);
        bus.mask_we = 1; bus.mask_wdata = 4'b0000;
        cyc();
        clear_flags();
        check("unmask_not_yet", 64'(bus.exc_o), 64'd0);
        cyc();
        check("unmask_exc", 64'(bus.exc_o), 64'd1);
        check("unmask_esr", 64'(bus.esr_o), 64'h1);
        cyc();
        do_eret();

        // IRQ beats simultaneous invalid opcode; opcode re-faults after return
        bus.irq_i = 4'b0100;
        cyc();
        bus.instr_valid = 1; bus.not_an_instr = 1; bus.pc_i = 64'h80;
        cyc();
        clear_flags();
        check("irq_wins_esr", 64'(bus.esr_o), 64'h4);
        check("irq_wins_elr", bus.elr_o, 64'h80);
        cyc();
        do_eret();
        bus.instr_valid = 1; bus.not_an_instr = 1;
        cyc();
        clear_flags();
        check("refault_esr", 64'(bus.esr_o), 64'h2);
        cyc();

        // Invalid opcode inside the handler
        bus.instr_valid = 1; bus.not_an_instr = 1;
        cyc();
        clear_flags();
        check("hdl_inv_dbl", 64'(bus.dbl_fault_o), 64'(DBL_EN));
        check("hdl_inv_no_exc", 64'(bus.exc_o), 64'd0);
        bus.instr_valid = 1; bus.eret = 1;
        cyc();
        clear_flags();
        check("hdl_inv_eret", 64'(bus.eret_o), DBL_EN ? 64'd0 : 64'd1);
        cyc(); cyc();

        // Reset while in handler with pending state
        reset = 1; cyc(); reset = 0;
        bus.irq_i = '0; cyc();
        bus.instr_valid = 1; bus.not_an_instr = 1;
        cyc();
        clear_flags();
        cyc();
        bus.irq_i = 4'b1000;
        cyc();
        check("pre_rst_pend", 64'(bus.pending_o), 64'b1000);
        check("pre_rst_hdl", 64'(bus.in_handler_o), 64'd1);
        reset = 1;
        cyc();
        reset = 0;
        check("rst_pend", 64'(bus.pending_o), 64'd0);
        check("rst_esr", 64'(bus.esr_o), 64'd0);
        check("rst_elr", bus.elr_o, 64'd0);
        check("rst_hdl", 64'(bus.in_handler_o), 64'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) bus.irq_i[b] = ~bus.irq_i[b];
            bus.mask_we      = ($urandom_range(31) == 0);
            bus.mask_wdata   = N'($urandom);
            bus.instr_valid  = ($urandom_range(3) != 0);
            bus.not_an_instr = ($urandom_range(15) == 0);
            bus.eret         = ($urandom_range(3) == 0);
            bus.pc_i         = {$urandom, $urandom};
            reset            = ($urandom_range(499) == 0);
            cyc();
        end
        reset = 0;
        clear_flags();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
